// File: rtl/stream_mux_pkg.sv
// rtl/stream_mux_pkg.sv - shared state encoding and select-width helper for stream_mux_nx1
package stream_mux_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } mux_state_e;

    // Channel-index width: ceil(log2(n)), never narrower than one bit.
    function automatic int sel_width(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/stream_out_reg.sv
// rtl/stream_out_reg.sv - single-entry valid/ready output register with full throughput
module stream_out_reg #(
    parameter int DW = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          out_ready,
    output logic          slot_free,
    output logic [DW-1:0] out_data,
    output logic          out_valid
);

    logic [DW-1:0] data_q, data_d;
    logic          valid_q, valid_d;

    // Slot may be refilled whenever it is empty or being drained this cycle.
    always_comb begin
        slot_free = !valid_q || out_ready;
        data_d    = data_q;
        valid_d   = valid_q;
        if (push) begin
            data_d  = push_data;
            valid_d = 1'b1;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    // Register stage; data only changes on a push so a stalled beat stays stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;

endmodule

// File: rtl/stream_mux_nx1.sv
// rtl/stream_mux_nx1.sv - N-to-1 packet-atomic stream mux; define STREAM_MUX_RR_EN for round-robin arbitration
module stream_mux_nx1
    import stream_mux_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [sel_width(N_CH)-1:0]    sel,
    input  logic [N_CH*WIDTH-1:0]         in_data,
    input  logic [N_CH-1:0]               in_valid,
    input  logic [N_CH-1:0]               in_last,
    output logic [N_CH-1:0]               in_ready,
    output logic [WIDTH-1:0]              out_data,
    output logic                          out_valid,
    output logic                          out_last,
    input  logic                          out_ready,
    output logic                          busy,
    output logic [sel_width(N_CH)-1:0]    cur_ch,
    output logic                          sel_err
);

    localparam int SEL_W = sel_width(N_CH);

    mux_state_e       state_q, state_d;
    logic [SEL_W-1:0] cur_ch_q, cur_ch_d;
    logic             sel_err_q, sel_err_d;

    logic [SEL_W-1:0] grant;
    logic             grant_ok;
    logic [WIDTH-1:0] grant_data;
    logic             grant_last;
    logic             grant_valid;
    logic             slot_free;
    logic             xfer;
    logic [WIDTH:0]   reg_data;

    // Pick the granted channel: locked channel mid-packet, otherwise sel or round-robin winner.
    always_comb begin
        grant    = cur_ch_q;
        grant_ok = 1'b1;
        if (state_q == IDLE) begin
`ifdef STREAM_MUX_RR_EN
            grant_ok = 1'b0;
            // Descending scan so the nearest channel after cur_ch is the last to overwrite.
            for (int k = N_CH; k >= 1; k--) begin
                if (in_valid[(int'(cur_ch_q) + k) % N_CH]) begin
                    grant    = SEL_W'((int'(cur_ch_q) + k) % N_CH);
                    grant_ok = 1'b1;
                end
            end
`else
            grant    = sel;
            grant_ok = (32'(sel) < 32'(N_CH));
`endif
        end
    end

    // Route the granted channel's beat and drive the one-hot ready.
    always_comb begin
        grant_data  = '0;
        grant_last  = 1'b0;
        grant_valid = 1'b0;
        in_ready    = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (grant == SEL_W'(i)) begin
                grant_data  = in_data[i*WIDTH +: WIDTH];
                grant_last  = in_last[i];
                grant_valid = in_valid[i];
                in_ready[i] = slot_free && grant_ok;
            end
        end
        xfer = grant_valid && grant_ok && slot_free;
    end

    // Packet-lock FSM next state, granted-channel tracking and sticky select error.
    always_comb begin
        state_d   = state_q;
        cur_ch_d  = cur_ch_q;
        sel_err_d = sel_err_q;
        case (state_q)
            IDLE: begin
`ifdef STREAM_MUX_RR_EN
                if (xfer) cur_ch_d = grant;
`else
                if (grant_ok) cur_ch_d  = sel;
                else          sel_err_d = 1'b1;
`endif
                if (xfer && !grant_last) state_d = LOCKED;
            end
            LOCKED: begin
                if (xfer && grant_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cur_ch_q  <= '0;
            sel_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_ch_q  <= cur_ch_d;
            sel_err_q <= sel_err_d;
        end
    end

    stream_out_reg #(
        .DW (WIDTH + 1)
    ) u_out_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (xfer),
        .push_data ({grant_last, grant_data}),
        .out_ready (out_ready),
        .slot_free (slot_free),
        .out_data  (reg_data),
        .out_valid (out_valid)
    );

    assign out_data = reg_data[WIDTH-1:0];
    assign out_last = reg_data[WIDTH];
    assign busy     = (state_q == LOCKED);
    assign cur_ch   = cur_ch_q;
    assign sel_err  = sel_err_q;

endmodule

// File: tb/tb_stream_mux_nx1.sv
// tb/tb_stream_mux_nx1.sv - self-checking bench for stream_mux_nx1 (4-channel and 3-channel instances)
module tb_stream_mux_nx1;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int SW = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [SW-1:0]   sel;
    logic [N*W-1:0]  in_data;
    logic [N-1:0]    in_valid, in_last, in_ready;
    logic [W-1:0]    out_data;
    logic            out_valid, out_last, out_ready, busy, sel_err;
    logic [SW-1:0]   cur_ch;

    logic [1:0]      sel3;
    logic [3*W-1:0]  in_data3;
    logic [2:0]      in_valid3, in_last3, in_ready3;
    logic [W-1:0]    out_data3;
    logic            out_valid3, out_last3, out_ready3, busy3, sel_err3;
    logic [1:0]      cur_ch3;

    int nvec  = 0;
    int nfail = 0;

    // Reference model: expected output slot, lock state, granted channel, error flag.
    bit         m_locked, m_err, m_ov, m_ol;
    int         m_cur;
    logic [7:0] m_od;
    logic [8:0] sb_q[$];
    int         acc;

    always #5 clk = ~clk;

    stream_mux_nx1 #(.N_CH(N), .WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .sel(sel), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
        .out_last(out_last), .out_ready(out_ready), .busy(busy), .cur_ch(cur_ch), .sel_err(sel_err)
    );

    stream_mux_nx1 #(.N_CH(3), .WIDTH(W)) dut3 (
        .clk(clk), .rst_n(rst_n), .sel(sel3), .in_data(in_data3), .in_valid(in_valid3),
        .in_last(in_last3), .in_ready(in_ready3), .out_data(out_data3), .out_valid(out_valid3),
        .out_last(out_last3), .out_ready(out_ready3), .busy(busy3), .cur_ch(cur_ch3), .sel_err(sel_err3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_locked = 0; m_err = 0; m_ov = 0; m_ol = 0; m_cur = 0; m_od = '0;
        sb_q.delete();
    endtask

    task automatic set_ch(input int c, input logic [7:0] d, input logic v, input logic l);
        in_data[c*W +: W] = d;
        in_valid[c]       = v;
        in_last[c]        = l;
    endtask

    // One clock: check combinational ready and the consumed beat at negedge, registered outputs after the edge.
    task automatic cycle(output int accepted);
        int g;
        bit ok, sf, xf;
        logic [N-1:0] er;
        logic [8:0] exp_beat;
        @(negedge clk);
        sf = !m_ov || out_ready;
        g  = m_cur;
        ok = 1;
        if (!m_locked) begin
`ifdef STREAM_MUX_RR_EN
            ok = 0;
            for (int k = 1; k <= N; k++) begin
                if (in_valid[(m_cur + k) % N]) begin
                    g  = (m_cur + k) % N;
                    ok = 1;
                    break;
                end
            end
`else
            g  = int'(sel);
            ok = (g < N);
`endif
        end
        er = '0;
        if (ok && sf) er[g] = 1'b1;
        check("in_ready", 32'(in_ready), 32'(er));
        if (out_valid && out_ready) begin
            if (sb_q.size() > 0) begin
                exp_beat = sb_q.pop_front();
                check("sb_beat", 32'({out_last, out_data}), 32'(exp_beat));
            end else begin
                check("sb_underrun", 32'(sb_q.size()), 32'd1);
            end
        end
        xf = ok && sf && in_valid[g];
        accepted = xf ? g : -1;
        if (xf) begin
            sb_q.push_back({in_last[g], in_data[g*W +: W]});
            m_ov = 1; m_od = in_data[g*W +: W]; m_ol = in_last[g];
        end else if (out_ready) begin
            m_ov = 0;
        end
        if (!m_locked) begin
`ifdef STREAM_MUX_RR_EN
            if (xf) m_cur = g;
`else
            if (ok) m_cur = g;
            else    m_err = 1;
`endif
            if (xf && !in_last[g]) m_locked = 1;
        end else if (xf && in_last[g]) begin
            m_locked = 0;
        end
        @(posedge clk);
        #1;
        check("out_valid", 32'(out_valid), 32'(m_ov));
        if (m_ov) begin
            check("out_data", 32'(out_data), 32'(m_od));
            check("out_last", 32'(out_last), 32'(m_ol));
        end
        check("busy", 32'(busy), 32'(m_locked));
        check("cur_ch", 32'(cur_ch), 32'(m_cur));
        check("sel_err", 32'(sel_err), 32'(m_err));
    endtask

    initial begin
        sel = '0; in_data = '0; in_valid = '0; in_last = '0; out_ready = 1'b0;
        sel3 = '0; in_data3 = '0; in_valid3 = '0; in_last3 = '0; out_ready3 = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cur_ch", 32'(cur_ch), 32'd0);
        check("rst_sel_err", 32'(sel_err), 32'd0);
        rst_n = 1'b1;
        out_ready = 1'b1;

`ifdef STREAM_MUX_RR_EN
        // Round-robin: ch0, ch1, ch3 hold single-beat packets; sel points elsewhere and is ignored.
        sel = 2'd2;
        set_ch(0, 8'h50, 1, 1); set_ch(1, 8'h51, 1, 1); set_ch(3, 8'h53, 1, 1);
        cycle(acc); check("rr_1", 32'(cur_ch), 32'd1);
        cycle(acc); check("rr_2", 32'(cur_ch), 32'd3);
        cycle(acc); check("rr_3", 32'(cur_ch), 32'd0);
        cycle(acc); check("rr_4", 32'(cur_ch), 32'd1);
        check("rr_sel_err", 32'(sel_err), 32'd0);
        in_valid = '0;
        cycle(acc);
`else
        // Basic routing: ch2 single beat 0xA5.
        sel = 2'd2;
        set_ch(2, 8'hA5, 1, 1);
        cycle(acc);
        check("basic_data", 32'(out_data), 32'hA5);
        check("basic_last", 32'(out_last), 32'd1);
        check("basic_busy", 32'(busy), 32'd0);
        in_valid = '0;
        cycle(acc);

        // Packet lock: ch1 sends 11/22/33, sel moves to 3 after beat 1, ch3 waits.
        sel = 2'd1;
        set_ch(1, 8'h11, 1, 0);
        cycle(acc);
        check("lock_b1", 32'(out_data), 32'h11);
        check("lock_busy1", 32'(busy), 32'd1);
        sel = 2'd3;
        set_ch(3, 8'h77, 1, 1);
        set_ch(1, 8'h22, 1, 0);
        cycle(acc);
        check("lock_b2", 32'(out_data), 32'h22);
        check("lock_busy2", 32'(busy), 32'd1);
        set_ch(1, 8'h33, 1, 1);
        cycle(acc);
        check("lock_b3", 32'(out_data), 32'h33);
        check("lock_busy3", 32'(busy), 32'd0);
        in_valid[1] = 1'b0;
        cycle(acc);
        check("lock_ch3", 32'(out_data), 32'h77);
        in_valid = '0;
        cycle(acc);

        // Backpressure: hold 0x40 for 3 stalled cycles, then 0x41 follows.
        sel = 2'd0;
        set_ch(0, 8'h40, 1, 0);
        cycle(acc);
        out_ready = 1'b0;
        set_ch(0, 8'h41, 1, 1);
        for (int i = 0; i < 3; i++) begin
            cycle(acc);
            check("bp_hold", 32'(out_data), 32'h40);
        end
        out_ready = 1'b1;
        cycle(acc);
        check("bp_next", 32'(out_data), 32'h41);
        in_valid = '0;
        sel = 2'd2;
        for (int i = 0; i < 4; i++) begin
            set_ch(2, 8'(8'hC0 + i), 1, 1);
            cycle(acc);
            check("thru", 32'(out_data), 32'(8'hC0 + i));
        end
        in_valid = '0;
        cycle(acc);

        // Bad select on the 3-channel instance.
        check("bad_err0", 32'(sel_err3), 32'd0);
        sel3 = 2'd3;
        in_data3 = 24'h0000C3; in_valid3 = 3'b001; in_last3 = 3'b001;
        @(negedge clk);
        check("bad_ready", 32'(in_ready3), 32'd0);
        @(posedge clk); #1;
        check("bad_err1", 32'(sel_err3), 32'd1);
        check("bad_ovalid", 32'(out_valid3), 32'd0);
        check("bad_cur", 32'(cur_ch3), 32'd0);
        sel3 = 2'd0;
        @(negedge clk);
        check("bad_ready0", 32'(in_ready3), 32'd1);
        @(posedge clk); #1;
        check("bad_pass", 32'(out_data3), 32'hC3);
        check("bad_pass_v", 32'(out_valid3), 32'd1);
        check("bad_sticky", 32'(sel_err3), 32'd1);
        in_valid3 = '0;
`endif

        // Reset mid-packet, asserted between edges.
        sel = 2'd1;
        in_valid = '0;
        set_ch(1, 8'h99, 1, 0);
        cycle(acc);
        check("mid_busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_cur", 32'(cur_ch), 32'd0);
        model_reset();
        sel = '0;
        in_valid = '0;
        in_last = '0;
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        sel = 2'd2;
        set_ch(2, 8'h5A, 1, 1);
        cycle(acc);
        check("post_rst_cur", 32'(cur_ch), 32'd2);
        in_valid = '0;
        cycle(acc);

        // Randomised traffic; a channel's beat stays put until it is accepted.
        acc = -1;
        for (int it = 0; it < 400; it++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            sel = SW'($urandom_range(0, N - 1));
            for (int c = 0; c < N; c++) begin
                if (!in_valid[c] || acc == c) begin
                    in_valid[c] = 1'($urandom_range(0, 1));
                    in_data[c*W +: W] = 8'($urandom);
                    in_last[c] = ($urandom_range(0, 2) == 0);
                end
            end
            cycle(acc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
